fifo_param: RTL

Parametrised synchronous FIFO: the successor to the fixed depth-4 FIFO control logic, with data storage, configurable width and depth, almost-full/almost-empty flags, an occupancy count and sticky overflow/underflow errors. It sits between a producer using a `data_in_valid` strobe and a consumer using a `pop_fifo` strobe, both in one clock domain. Output is first-word-fall-through: the head entry is always visible on `data_out` while the FIFO is not empty.

---
 rtl/fifo_param_pkg.sv | 19 +
 rtl/fifo_param_mem.sv | 31 +++
 rtl/fifo_param.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fifo_param_pkg.sv
// Shared defaults for the parametrised FIFO, plus the width helper used to size
// the pointers and the occupancy counter.
package fifo_param_pkg;

   localparam int DEFAULT_DATA_WIDTH = 16;
   localparam int DEFAULT_DEPTH      = 4;
   localparam int DEFAULT_AE_LEVEL   = 1;

   // Smallest number of bits b with 2**b >= value; clog2(1) is 0.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/fifo_param_mem.sv
// Storage for the FIFO: a DEPTH x DATA_WIDTH register array with one synchronous
// write port and one asynchronous read port. The array is deliberately not reset,
// so the head word is meaningless until something has been written.
module fifo_mem
   import fifo_param_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int DEPTH      = DEFAULT_DEPTH,
   parameter int ADDR_W     = clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_W-1:0]     raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Write port: the addressed entry captures wdata on the rising edge when we is high.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // The read port is combinational, which is what makes the FIFO first-word-fall-through.
   assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with first-word-fall-through output.
// The occupancy counter is the real state; full/empty and the almost flags are
// all decoded from it, so they change only on clock edges. Rejected pushes and
// pops are remembered in sticky error flags until err_clr.
module fifo_param
   import fifo_param_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int DEPTH      = DEFAULT_DEPTH,
   parameter int AF_LEVEL   = DEPTH - 1,
   parameter int AE_LEVEL   = DEFAULT_AE_LEVEL
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [DATA_WIDTH-1:0]      data_in,
   input  logic                       data_in_valid,
   input  logic                       pop_fifo,
   input  logic                       err_clr,
   output logic [DATA_WIDTH-1:0]      data_out,
   output logic                       fifo_empty,
   output logic                       fifo_full,
   output logic                       almost_empty,
   output logic                       almost_full,
   output logic [clog2(DEPTH+1)-1:0]  count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int PTR_W = clog2(DEPTH);
   localparam int CNT_W = clog2(DEPTH + 1);

   // Thresholds pre-cast to the counter width so the flag compares are width-exact.
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
   localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_next;

   logic is_empty;
   logic is_full;
   logic push_ok;
   logic pop_ok;
   logic overflow_evt;
   logic underflow_evt;

   // Full and empty come straight from the registered occupancy.
   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == DEPTH_CNT);

   // A push into a full FIFO is still fine when a pop frees the head slot in the
   // same cycle; a pop is only honoured when there is something to pop.
   assign push_ok = data_in_valid & (~is_full | pop_fifo);
   assign pop_ok  = pop_fifo & ~is_empty;

   // Error events are exactly the requests that the qualification above turned away.
   assign overflow_evt  = data_in_valid & is_full & ~pop_fifo;
   assign underflow_evt = pop_fifo & is_empty;

   // Next occupancy: up on a lone accepted push, down on a lone accepted pop,
   // otherwise unchanged (including the simultaneous push-and-pop case).
   always_comb begin
      count_next = count_q;
      if (push_ok && !pop_ok) begin
         count_next = count_q + CNT_W'(1);
      end else if (pop_ok && !push_ok) begin
         count_next = count_q - CNT_W'(1);
      end
   end

   // Pointer and occupancy registers; pointers roll over naturally because DEPTH
   // is a power of two. Reset throws away the contents by zeroing all three.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count_q <= count_next;
      end
   end

   // Sticky error flags: set by an event, cleared by err_clr, and an event in the
   // same cycle as err_clr keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= overflow_evt  | (overflow  & ~err_clr);
         underflow <= underflow_evt | (underflow & ~err_clr);
      end
   end

   // Storage: written at wr_ptr on accepted pushes, head always visible at rd_ptr.
   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_W     (PTR_W)
   ) u_mem (
      .clk   (clk),
      .we    (push_ok),
      .waddr (wr_ptr),
      .wdata (data_in),
      .raddr (rd_ptr),
      .rdata (data_out)
   );

   // Status outputs decoded from the registered count.
   assign count        = count_q;
   assign fifo_empty   = is_empty;
   assign fifo_full    = is_full;
   assign almost_empty = (count_q <= AE_CNT);
   assign almost_full  = (count_q >= AF_CNT);

endmodule
